// File: rtl/weighted_rr_arbiter.sv
// Round-robin arbiter with sticky ownership and registered one-hot grant.
// Define WRR_WEIGHT_EN to add per-channel credit (weighted) release; otherwise weight is ignored.
module weighted_rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*CW-1:0]      weight,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic          arb_en;      // low for the first cycle after reset release
  logic          found;
  logic [IW-1:0] next_id;
  logic [N-1:0]  next_onehot;
  logic          force_rel;
  logic          hold;

  // Search order: ptr+1, ptr+2, ... wrapping, with ptr itself visited last.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    found   = 1'b0;
    next_id = '0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        next_id = idx[IW-1:0];
      end
    end
    next_onehot          = '0;
    next_onehot[next_id] = 1'b1;
  end

`ifdef WRR_WEIGHT_EN
  logic [CW-1:0] credit;
  logic [CW-1:0] new_credit;
  logic [CW-1:0] owner_credit;
  logic          others;

  always_comb begin
    new_credit   = weight[next_id*CW +: CW];
    owner_credit = weight[grant_id*CW +: CW];
    if (new_credit == '0)
      new_credit = CW'(1);
    if (owner_credit == '0)
      owner_credit = CW'(1);
    others    = |(req & ~grant);
    force_rel = (credit == CW'(1)) && others;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
    end else if (!arb_en) begin
      credit <= '0;
    end else if (hold) begin
      // Exhausted with nobody else waiting: start a fresh quantum.
      credit <= (credit == CW'(1)) ? owner_credit : credit - CW'(1);
    end else if (found) begin
      credit <= new_credit;
    end else begin
      credit <= '0;
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^weight;
  assign force_rel     = 1'b0;
`endif

  assign hold = grant_valid && req[grant_id] && !force_rel;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= IW'(N - 1);
      arb_en      <= 1'b0;
    end else begin
      arb_en <= 1'b1;
      if (!arb_en) begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
      end else if (hold) begin
        grant       <= grant;
        grant_valid <= grant_valid;
        grant_id    <= grant_id;
      end else if (found) begin
        grant       <= next_onehot;
        grant_valid <= 1'b1;
        grant_id    <= next_id;
        ptr         <= next_id;
      end else begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter (N=4, CW=4); covers the weighted
// sequence when WRR_WEIGHT_EN is defined and the plain sticky owner otherwise.
module tb_weighted_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_id;

  typedef struct {
    logic [3:0] grant;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  weighted_rr_arbiter #(.N(4), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .weight     (weight),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) id = 2'(i);
    return id;
  endfunction

  // Drive inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic [3:0] r, input logic rs, input logic [3:0] eg, input string tag);
    exp_t e;
    req = r;
    rst = rs;
    exp_q.push_back('{grant: eg, tag: tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (grant === e.grant) else begin
      errors++;
      $error("FAIL %s grant got %b exp %b", e.tag, grant, e.grant);
    end
    checks++;
    assert (grant_valid === (|e.grant)) else begin
      errors++;
      $error("FAIL %s grant_valid got %b exp %b", e.tag, grant_valid, |e.grant);
    end
    checks++;
    assert (grant_id === id_of(e.grant)) else begin
      errors++;
      $error("FAIL %s grant_id got %0d exp %0d", e.tag, grant_id, id_of(e.grant));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat [5];
    rst    = 1'b1;
    req    = 4'b0000;
    weight = 16'hFFFF;

    step(4'b0101, 1'b1, 4'b0000, "reset");
    step(4'b0101, 1'b0, 4'b0000, "first_cycle_idle");
    step(4'b0101, 1'b0, 4'b0001, "first_grant_idx0");
    step(4'b0101, 1'b0, 4'b0001, "hold0");
    step(4'b0100, 1'b0, 4'b0100, "handoff_to2");
    step(4'b1000, 1'b0, 4'b1000, "handoff_to3");
    step(4'b1001, 1'b0, 4'b1000, "hold3");
    step(4'b0001, 1'b0, 4'b0001, "wrap_to0");
    step(4'b0000, 1'b0, 4'b0000, "idle");
    step(4'b0000, 1'b0, 4'b0000, "idle2");
    step(4'b1111, 1'b0, 4'b0010, "resume_after_ptr0");
    step(4'b1111, 1'b0, 4'b0010, "hold1");
    step(4'b0100, 1'b0, 4'b0100, "handoff_1_to_2");
    step(4'b0100, 1'b1, 4'b0000, "reset_mid_grant");
    step(4'b1100, 1'b0, 4'b0000, "post_reset_idle");
    step(4'b1100, 1'b0, 4'b0100, "post_reset_from0");
    step(4'b1100, 1'b0, 4'b0100, "post_reset_hold");

    weight = 16'h0000;
    step(4'b1111, 1'b1, 4'b0000, "reset2");
    step(4'b1111, 1'b0, 4'b0000, "reset2_idle");
    step(4'b1111, 1'b0, 4'b0001, "all_req_grant0");

`ifdef WRR_WEIGHT_EN
    weight = 16'hF032;  // w0=2 w1=3 w2=0 w3=15
    step(4'b0011, 1'b1, 4'b0000, "w_reset");
    step(4'b0011, 1'b0, 4'b0000, "w_idle");
    pat[0] = 4'b0001;
    pat[1] = 4'b0001;
    pat[2] = 4'b0010;
    pat[3] = 4'b0010;
    pat[4] = 4'b0010;
    for (int i = 0; i < 15; i++)
      step(4'b0011, 1'b0, pat[i % 5], $sformatf("w_seq%0d", i));
    step(4'b0100, 1'b0, 4'b0100, "w_zero_weight_grant");
    for (int i = 0; i < 10; i++)
      step(4'b0100, 1'b0, 4'b0100, $sformatf("w_lone_hold%0d", i));
    step(4'b0110, 1'b0, 4'b0010, "w_zero_weight_release");
`else
    pat[0] = 4'b0001;
    for (int i = 0; i < 20; i++)
      step(4'b1111, 1'b0, pat[0], $sformatf("sticky0_%0d", i));
    step(4'b1110, 1'b0, 4'b0010, "drop0_to1");
    step(4'b1110, 1'b0, 4'b0010, "hold1_after_drop");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
